// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The master drives requests and write data; the slave (the FIFO) returns
// read data, occupancy and status flags.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 8
);
    logic              flush;
    logic [DATA_W-1:0] din;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, din, write, read,
        input  dout, dout_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  flush, din, write, read,
        output dout, dout_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO for the Ethernet RX datapath.
// All 2**ADDR_W entries are usable; occupancy is tracked in an explicit counter
// so the status flags decode from registered state only. Read mode is either
// standard (registered dout, one-cycle dout_valid pulse) or first-word-fall-through.
module sync_fifo_param #(
    parameter int unsigned DATA_W   = 256,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned AF_LEVEL = 252,
    parameter int unsigned AE_LEVEL = 4,
    parameter int unsigned FWFT     = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    sync_fifo_param_if.slave ff_if
);

    localparam int unsigned     DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W + 1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    // Threshold sanity: the almost flags must not overlap and must be reachable.
    if (AE_LEVEL >= AF_LEVEL) begin : g_err_level_order
        $error("sync_fifo_param: AE_LEVEL (%0d) must be below AF_LEVEL (%0d)", AE_LEVEL, AF_LEVEL);
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_err_af_range
        $error("sync_fifo_param: AF_LEVEL (%0d) outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (AE_LEVEL >= DEPTH) begin : g_err_ae_range
        $error("sync_fifo_param: AE_LEVEL (%0d) outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              empty;
    logic              full;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] head_word;

    assign empty     = (count_q == '0);
    assign full      = (count_q == DEPTH_CNT);
    assign head_word = mem_q[rd_ptr_q];

    // Next-state: flush wins over everything; otherwise accept what pre-edge state allows.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        wr_acc       = 1'b0;
        rd_acc       = 1'b0;

        if (ff_if.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            dout_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            wr_acc = ff_if.write && !full;
            rd_acc = ff_if.read && !empty;

            if (ff_if.write && full) begin
                overflow_d = 1'b1;
            end
            if (ff_if.read && empty) begin
                underflow_d = 1'b1;
            end

            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_d     = rd_ptr_q + PTR_ONE;
                dout_d       = head_word;
                dout_valid_d = 1'b1;
            end

            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control and status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage array: written on accepted writes only, never reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= ff_if.din;
        end
    end

    // FWFT presents the head entry directly; standard mode uses the popped-word register.
    assign ff_if.dout         = (FWFT != 0) ? head_word : dout_q;
    assign ff_if.dout_valid   = (FWFT != 0) ? !empty : dout_valid_q;
    assign ff_if.empty        = empty;
    assign ff_if.full         = full;
    assign ff_if.almost_empty = (count_q <= AE_CNT);
    assign ff_if.almost_full  = (count_q >= AF_CNT);
    assign ff_if.count        = count_q;
    assign ff_if.overflow     = overflow_q;
    assign ff_if.underflow    = underflow_q;

endmodule
